// File: rtl/csr_host_if.sv
// Two-port host request/response bundle for the CSR host arbiter.
// Each port has its own valid/ready pair; read data and error are shared.
interface csr_host_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0]             req_we;
  logic [1:0][ADDR_W-1:0] req_addr;
  logic [1:0][DATA_W-1:0] req_wdata;
  logic [1:0]             rsp_valid;
  logic [1:0]             rsp_ready;
  logic [DATA_W-1:0]      rsp_rdata;
  logic                   rsp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );
endinterface

// File: rtl/csr_host_arbiter.sv
// Round-robin arbiter giving two off-chip hosts access to the CSR file.
// Each access runs IDLE -> ISSUE -> RESP; only one is ever in flight.
module csr_host_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  csr_host_if.slave         host,
  output logic [ADDR_W-1:0] csr_addr,
  output logic              csr_wen,
  output logic [DATA_W-1:0] csr_wdata,
  input  logic [DATA_W-1:0] csr_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              rr_q;
  logic              g_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              win;
  logic              accept;
  logic              hs;
  logic              ro_hit;

  // MSB set addresses the on-chip-written half, read-only to hosts
  assign ro_hit = addr_q[ADDR_W-1];

  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      (&host.req_valid):         win = rr_q;
      (host.req_valid == 2'b10): win = 1'b1;
      default:                   win = 1'b0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    host.req_ready = '0;
    host.rsp_valid = '0;
    csr_wen        = 1'b0;
    accept         = 1'b0;
    hs             = 1'b0;
    unique case (state_q)
      IDLE: begin
        if ((|host.req_valid) && !rst) begin
          host.req_ready[win] = 1'b1;
          accept              = 1'b1;
          state_d             = ISSUE;
        end
      end
      ISSUE: begin
        csr_wen = we_q & ~ro_hit;
        state_d = RESP;
      end
      RESP: begin
        host.rsp_valid[g_q] = 1'b1;
        if (host.rsp_ready[g_q]) begin
          hs      = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      g_q     <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        g_q     <= win;
        we_q    <= host.req_we[win];
        addr_q  <= host.req_addr[win];
        wdata_q <= host.req_wdata[win];
      end
      if (state_q == ISSUE) begin
        rdata_q <= we_q ? '0 : csr_rdata;
        err_q   <= we_q & ro_hit;
      end
      if (hs) begin
        rr_q <= ~g_q;
      end
    end
  end

  // address/data registers double as the CSR bus; wen alone qualifies it
  assign csr_addr       = addr_q;
  assign csr_wdata      = wdata_q;
  assign host.rsp_rdata = rdata_q;
  assign host.rsp_err   = err_q;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_csr_host_arbiter.sv
// Directed bench for csr_host_arbiter with a behavioural CSR file.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_csr_host_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  csr_addr;
  logic        csr_wen;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        busy;
  logic [31:0] rf [0:31];
  int          wen_cnt = 0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  csr_host_if host ();

  csr_host_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .host      (host),
    .csr_addr  (csr_addr),
    .csr_wen   (csr_wen),
    .csr_wdata (csr_wdata),
    .csr_rdata (csr_rdata),
    .busy      (busy)
  );

  assign csr_rdata = rf[csr_addr];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++)
        rf[i] <= 32'hA000_0000 | i;
    end else if (csr_wen === 1'b1) begin
      rf[csr_addr] <= csr_wdata;
      wen_cnt      <= wen_cnt + 1;
    end
  end

  task automatic test_reset;
    rst             = 1'b1;
    host.req_valid  = 2'b01;
    host.req_we     = 2'b00;
    host.req_addr   = '0;
    host.req_wdata  = '0;
    host.rsp_ready  = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (host.req_ready !== 2'b00) begin
      errors++;
      $display("FAIL rst_req_ready got=%b exp=00",
               host.req_ready);
    end
    checks++;
    if (host.rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL rst_rsp_valid got=%b exp=00",
               host.rsp_valid);
    end
    checks++;
    if (host.rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_rsp_rdata got=%h exp=0",
               host.rsp_rdata);
    end
    checks++;
    if (host.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_rsp_err got=%b exp=0",
               host.rsp_err);
    end
    checks++;
    if (csr_addr !== 5'h0 || csr_wen !== 1'b0) begin
      errors++;
      $display("FAIL rst_csr got=%h/%b exp=0/0",
               csr_addr, csr_wen);
    end
    checks++;
    if (csr_wdata !== 32'h0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_wdata_busy got=%h/%b exp=0/0",
               csr_wdata, busy);
    end
    @(posedge clk); #1;
    rst            = 1'b0;
    host.req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || host.req_ready !== 2'b00) begin
      errors++;
      $display("FAIL idle_busy got=%b/%b exp=0/00",
               busy, host.req_ready);
    end
  endtask

  task automatic test_write_read;
    int w0;
    @(posedge clk); #1;
    w0                = wen_cnt;
    host.req_valid    = 2'b01;
    host.req_we       = 2'b01;
    host.req_addr[0]  = 5'h03;
    host.req_wdata[0] = 32'hDEAD_BEEF;
    host.rsp_ready    = 2'b01;
    @(negedge clk);
    checks++;
    if (host.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL wr_grant got=%b exp=01",
               host.req_ready);
    end
    @(posedge clk); #1;
    host.req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (csr_wen !== 1'b1 || csr_addr !== 5'h03) begin
      errors++;
      $display("FAIL wr_issue got=%b/%h exp=1/03",
               csr_wen, csr_addr);
    end
    checks++;
    if (csr_wdata !== 32'hDEAD_BEEF || busy !== 1'b1) begin
      errors++;
      $display("FAIL wr_wdata got=%h/%b exp=deadbeef/1",
               csr_wdata, busy);
    end
    @(negedge clk);
    checks++;
    if (host.rsp_valid !== 2'b01 || host.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL wr_resp got=%b/%b exp=01/0",
               host.rsp_valid, host.rsp_err);
    end
    checks++;
    if (host.rsp_rdata !== 32'h0 || csr_wen !== 1'b0) begin
      errors++;
      $display("FAIL wr_rdata got=%h/%b exp=0/0",
               host.rsp_rdata, csr_wen);
    end
    checks++;
    if (wen_cnt - w0 !== 1 || rf[3] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wr_commit got=%0d/%h exp=1/deadbeef",
               wen_cnt - w0, rf[3]);
    end
    @(negedge clk);
    checks++;
    if (host.rsp_valid !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wr_done got=%b/%b exp=00/0",
               host.rsp_valid, busy);
    end
    @(posedge clk); #1;
    host.req_valid = 2'b01;
    host.req_we    = 2'b00;
    @(negedge clk);
    checks++;
    if (host.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rd_grant got=%b exp=01",
               host.req_ready);
    end
    @(posedge clk); #1;
    host.req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (csr_wen !== 1'b0 || csr_addr !== 5'h03) begin
      errors++;
      $display("FAIL rd_issue got=%b/%h exp=0/03",
               csr_wen, csr_addr);
    end
    @(negedge clk);
    checks++;
    if (host.rsp_valid !== 2'b01 ||
        host.rsp_rdata !== 32'hDEAD_BEEF ||
        host.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL rd_resp got=%b/%h/%b exp=01/deadbeef/0",
               host.rsp_valid, host.rsp_rdata, host.rsp_err);
    end
    @(negedge clk);
    checks++;
    if (host.rsp_valid !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rd_done got=%b/%b exp=00/0",
               host.rsp_valid, busy);
    end
  endtask

  task automatic test_ro_write;
    int w0;
    @(posedge clk); #1;
    w0                = wen_cnt;
    host.req_valid    = 2'b10;
    host.req_we       = 2'b10;
    host.req_addr[1]  = 5'h10;
    host.req_wdata[1] = 32'h1234_5678;
    host.rsp_ready    = 2'b10;
    @(negedge clk);
    checks++;
    if (host.req_ready !== 2'b10) begin
      errors++;
      $display("FAIL ro_grant got=%b exp=10",
               host.req_ready);
    end
    @(posedge clk); #1;
    host.req_valid = 2'b00;
    @(negedge clk);
    checks++;
    if (csr_wen !== 1'b0 || csr_addr !== 5'h10) begin
      errors++;
      $display("FAIL ro_issue got=%b/%h exp=0/10",
               csr_wen, csr_addr);
    end
    @(negedge clk);
    checks++;
    if (host.rsp_valid !== 2'b10 || host.rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL ro_resp got=%b/%b exp=10/1",
               host.rsp_valid, host.rsp_err);
    end
    checks++;
    if (host.rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL ro_rdata got=%h exp=0",
               host.rsp_rdata);
    end
    checks++;
    if (wen_cnt !== w0 || rf[16] !== 32'hA000_0010) begin
      errors++;
      $display("FAIL ro_nowrite got=%0d/%h exp=%0d/a0000010",
               wen_cnt, rf[16], w0);
    end
    @(negedge clk);
    checks++;
    if (host.rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL ro_done got=%b exp=00",
               host.rsp_valid);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0]  g;
    logic [1:0]  exp_g;
    logic [31:0] exp_d;
    int          n;
    @(posedge clk); #1;
    host.req_we      = 2'b00;
    host.req_addr[0] = 5'h01;
    host.req_addr[1] = 5'h02;
    host.rsp_ready   = 2'b11;
    host.req_valid   = 2'b11;
    for (int i = 0; i < 6; i++) begin
      exp_g = (i % 2 == 1) ? 2'b10 : 2'b01;
      exp_d = (i % 2 == 1) ? 32'hA000_0002
                           : 32'hA000_0001;
      n = 0;
      @(negedge clk);
      while (host.req_ready === 2'b00 && n < 10) begin
        @(negedge clk);
        n++;
      end
      g = host.req_ready;
      checks++;
      if (g !== exp_g) begin
        errors++;
        $display("FAIL rr_grant%0d got=%b exp=%b",
                 i, g, exp_g);
      end
      n = 0;
      @(negedge clk);
      while (host.rsp_valid === 2'b00 && n < 10) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (host.rsp_valid !== exp_g ||
          host.rsp_rdata !== exp_d) begin
        errors++;
        $display("FAIL rr_resp%0d got=%b/%h exp=%b/%h",
                 i, host.rsp_valid, host.rsp_rdata,
                 exp_g, exp_d);
      end
    end
    @(posedge clk); #1;
    host.req_valid = 2'b00;
  endtask

  task automatic test_backpressure;
    @(posedge clk); #1;
    host.req_we      = 2'b00;
    host.req_addr[0] = 5'h03;
    host.req_addr[1] = 5'h01;
    host.rsp_ready   = 2'b00;
    host.req_valid   = 2'b11;
    @(negedge clk);
    checks++;
    if (host.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL bp_grant0 got=%b exp=01",
               host.req_ready);
    end
    @(posedge clk); #1;
    host.req_valid = 2'b10;
    @(negedge clk);
    checks++;
    if (host.req_ready !== 2'b00) begin
      errors++;
      $display("FAIL bp_issue_rdy got=%b exp=00",
               host.req_ready);
    end
    @(negedge clk);
    checks++;
    if (host.rsp_valid !== 2'b01 ||
        host.rsp_rdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL bp_resp got=%b/%h exp=01/deadbeef",
               host.rsp_valid, host.rsp_rdata);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      host.rsp_ready = 2'b10;
      @(negedge clk);
      checks++;
      if (host.rsp_valid !== 2'b01 ||
          host.rsp_rdata !== 32'hDEAD_BEEF ||
          host.req_ready !== 2'b00) begin
        errors++;
        $display("FAIL bp_hold%0d got=%b/%h/%b exp=01/deadbeef/00",
                 i, host.rsp_valid, host.rsp_rdata,
                 host.req_ready);
      end
    end
    @(posedge clk); #1;
    host.rsp_ready = 2'b01;
    @(negedge clk);
    checks++;
    if (host.rsp_valid !== 2'b01) begin
      errors++;
      $display("FAIL bp_pre_hs got=%b exp=01",
               host.rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (host.req_ready !== 2'b10 ||
        host.rsp_valid !== 2'b00) begin
      errors++;
      $display("FAIL bp_grant1 got=%b/%b exp=10/00",
               host.req_ready, host.rsp_valid);
    end
    @(posedge clk); #1;
    host.req_valid = 2'b00;
    host.rsp_ready = 2'b10;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (host.rsp_valid !== 2'b10 ||
        host.rsp_rdata !== 32'hA000_0001) begin
      errors++;
      $display("FAIL bp_resp1 got=%b/%h exp=10/a0000001",
               host.rsp_valid, host.rsp_rdata);
    end
    @(negedge clk);
    checks++;
    if (host.rsp_valid !== 2'b00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_done got=%b/%b exp=00/0",
               host.rsp_valid, busy);
    end
  endtask

  task automatic test_reset_mid_resp;
    int w0;
    @(posedge clk); #1;
    w0               = wen_cnt;
    host.req_we      = 2'b00;
    host.req_addr[0] = 5'h02;
    host.rsp_ready   = 2'b00;
    host.req_valid   = 2'b01;
    @(posedge clk); #1;
    host.req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (host.rsp_valid !== 2'b01) begin
      errors++;
      $display("FAIL mid_resp got=%b exp=01",
               host.rsp_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (host.rsp_valid !== 2'b00 || busy !== 1'b0 ||
        host.rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL mid_async got=%b/%b/%h exp=00/0/0",
               host.rsp_valid, busy, host.rsp_rdata);
    end
    @(posedge clk); #1;
    rst            = 1'b0;
    host.rsp_ready = 2'b01;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (host.rsp_valid !== 2'b00 || busy !== 1'b0 ||
          wen_cnt !== w0) begin
        errors++;
        $display("FAIL mid_after%0d got=%b/%b/%0d exp=00/0/%0d",
                 i, host.rsp_valid, busy, wen_cnt, w0);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_ro_write();
    test_round_robin();
    test_backpressure();
    test_reset_mid_resp();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
